// File: rtl/alu_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_alu_pkg
//  Purpose  : Shared ALU control codes, R-type funct codes and the encoding
//             of the EX-stage multiply sequencer states.
//  Revision : 1.0  initial release
// ============================================================================
package mips_alu_pkg;

    // ALU control codes driven by the ALU control unit
    localparam logic [3:0] c_alucon_and = 4'b0000;
    localparam logic [3:0] c_alucon_or  = 4'b0001;
    localparam logic [3:0] c_alucon_add = 4'b0010;
    localparam logic [3:0] c_alucon_xor = 4'b0011;
    localparam logic [3:0] c_alucon_inc = 4'b0100;
    localparam logic [3:0] c_alucon_dec = 4'b0101;
    localparam logic [3:0] c_alucon_sub = 4'b0110;
    localparam logic [3:0] c_alucon_not = 4'b1000;
    localparam logic [3:0] c_alucon_nor = 4'b1100;

    // R-type funct field codes
    localparam logic [5:0] c_funct_add  = 6'b100000;
    localparam logic [5:0] c_funct_addu = 6'b100001;
    localparam logic [5:0] c_funct_sub  = 6'b100010;
    localparam logic [5:0] c_funct_subu = 6'b100011;
    localparam logic [5:0] c_funct_and  = 6'b100100;
    localparam logic [5:0] c_funct_or   = 6'b100101;
    localparam logic [5:0] c_funct_xor  = 6'b100110;
    localparam logic [5:0] c_funct_nor  = 6'b100111;
    localparam logic [5:0] c_funct_mul  = 6'b101000;
    localparam logic [5:0] c_funct_slt  = 6'b101010;

    // Multiply sequencer state encoding
    localparam int         c_st_w    = 2;
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_sequencer_if
//  Purpose  : EX-stage operand/control bundle plus the shared ALU port and
//             the multiply results. The sequencer uses the slave modport;
//             the surrounding pipeline and ALU use the master modport.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ex_valid;
    logic             ex_is_mul;
    logic             ex_flush;
    logic [3:0]       ex_alucon;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_con;
    logic             stall;
    logic             mul_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport slave (
        input  ex_valid, ex_is_mul, ex_flush, ex_alucon, ex_a, ex_b,
        input  alu_result, alu_carry,
        output alu_a, alu_b, alu_con, stall, mul_done, hi, lo
    );

    modport master (
        output ex_valid, ex_is_mul, ex_flush, ex_alucon, ex_a, ex_b,
        output alu_result, alu_carry,
        input  alu_a, alu_b, alu_con, stall, mul_done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_sequencer
//  Purpose  : Shares the single EX-stage ALU between ordinary ops and an
//             iterative unsigned shift-add multiply. While a MUL runs the
//             pipeline is stalled and the ALU performs one ADD per bit.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer
    import mips_alu_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         CNT_W      = 6,
    parameter logic [3:0] ALUCON_ADD = c_alucon_add
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_mul_sequencer_if.slave bus
);

    logic [c_st_w-1:0] r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mq;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic              r_mul_done;

    logic              w_idle;
    logic              w_run;
    logic              w_start;
    logic              w_last;

    assign w_idle  = (r_state == c_st_idle);
    assign w_run   = (r_state == c_st_run);
    // Gating by IDLE keeps the MUL still sitting in EX during DONE from restarting
    assign w_start = w_idle & bus.ex_valid & bus.ex_is_mul & ~bus.ex_flush;
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Stall must rise in the start cycle itself so IF/ID/EX hold the MUL
    assign bus.stall    = w_start | w_run;
    assign bus.mul_done = r_mul_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

    // ALU operand/control mux: sequencer owns the ALU only while iterating
    always_comb begin
        bus.alu_a   = bus.ex_a;
        bus.alu_b   = bus.ex_b;
        bus.alu_con = bus.ex_alucon;
        if (w_run) begin
            bus.alu_a   = r_acc;
            bus.alu_b   = r_mq[0] ? r_mcand : '0;
            bus.alu_con = ALUCON_ADD;
        end
    end

    // Sequencer FSM with iteration counter, acc/mq shift pair and HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mq       <= '0;
            r_mcand    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mul_done <= 1'b0;
        end else begin
            r_mul_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_mcand <= bus.ex_a;
                        r_mq    <= bus.ex_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    // Partial sum (with carry as its top bit) shifts right into acc,
                    // its LSB becomes the next settled product bit at the top of mq
                    r_acc <= {bus.alu_carry, bus.alu_result[WIDTH-1:1]};
                    r_mq  <= {bus.alu_result[0], r_mq[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.ex_flush) begin
                        r_state <= c_st_idle;
                    end else if (w_last) begin
                        r_state    <= c_st_done;
                        r_mul_done <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_hi    <= r_acc;
                    r_lo    <= r_mq;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mul_sequencer
//  Purpose  : Self-checking bench for alu_mul_sequencer with an external ALU
//             model, a cycle-level product model and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.WIDTH(W)) bus();

    alu_mul_sequencer #(
        .WIDTH      (W),
        .CNT_W      (6),
        .ALUCON_ADD (4'b0010)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External shared ALU
    always_comb begin
        bus.alu_result = '0;
        bus.alu_carry  = 1'b0;
        case (bus.alu_con)
            4'b0010: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = bus.alu_a ^ bus.alu_b;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cycles[$];
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.mul_done === 1'b1) done_cycles.push_back(cyc);

    // Behavioural model: a MUL occupies W run cycles, then one completion cycle
    // after which {hi,lo} holds the full unsigned product
    bit           m_busy = 1'b0;
    bit           m_done_now = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_a, m_b, m_hi, m_lo;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_done_now <= 1'b0;
            m_hi       <= '0;
            m_lo       <= '0;
        end else if (m_done_now) begin
            {m_hi, m_lo} <= 64'(m_a) * 64'(m_b);
            m_done_now   <= 1'b0;
        end else if (m_busy) begin
            if (bus.ex_flush) m_busy <= 1'b0;
            else if (m_left == 1) begin
                m_busy     <= 1'b0;
                m_done_now <= 1'b1;
            end else m_left <= m_left - 1;
        end else if (bus.ex_valid && bus.ex_is_mul && !bus.ex_flush) begin
            m_busy <= 1'b1;
            m_left <= W;
            m_a    <= bus.ex_a;
            m_b    <= bus.ex_b;
        end
    end

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit start_c;
            start_c = !m_busy && !m_done_now && bus.ex_valid && bus.ex_is_mul && !bus.ex_flush;
            check("stall", 64'(bus.stall), 64'(m_busy | start_c));
            check("mul_done", 64'(bus.mul_done), 64'(m_done_now));
            check("hi", 64'(bus.hi), 64'(m_hi));
            check("lo", 64'(bus.lo), 64'(m_lo));
            if (m_busy) begin
                check("alu_con_run", 64'(bus.alu_con), 64'(4'b0010));
            end else begin
                check("alu_a_pass", 64'(bus.alu_a), 64'(bus.ex_a));
                check("alu_b_pass", 64'(bus.alu_b), 64'(bus.ex_b));
                check("alu_con_pass", 64'(bus.alu_con), 64'(bus.ex_alucon));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a MUL in EX and hold it until completion; report stall length,
    // completion offset from the start cycle and lo seen in the start cycle
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int stall_cyc, output int done_off,
                           output logic [W-1:0] lo_at_start);
        bus.ex_valid  = 1'b1;
        bus.ex_is_mul = 1'b1;
        bus.ex_flush  = 1'b0;
        bus.ex_alucon = 4'b1111;
        bus.ex_a      = a;
        bus.ex_b      = b;
        stall_cyc     = 0;
        done_off      = -1;
        lo_at_start   = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) lo_at_start = bus.lo;
            if (bus.stall === 1'b1) stall_cyc++;
            if (bus.mul_done === 1'b1) begin
                done_off = i;
                break;
            end
        end
        if (done_off < 0) begin
            total++;
            bad++;
            $display("FAIL mul_timeout: actual=no mul_done required=mul_done within 100 cycles");
        end
        step();
        bus.ex_valid  = 1'b0;
        bus.ex_is_mul = 1'b0;
    endtask

    initial begin
        int sc, off, n0;
        logic [W-1:0] lo0;
        bus.ex_valid  = 1'b0;
        bus.ex_is_mul = 1'b0;
        bus.ex_flush  = 1'b0;
        bus.ex_alucon = 4'b0000;
        bus.ex_a      = '0;
        bus.ex_b      = '0;
        rst_n         = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        step();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_mul_done", 64'(bus.mul_done), 64'd0);

        // Non-MUL passthrough
        step();
        bus.ex_valid = 1'b1; bus.ex_is_mul = 1'b0; bus.ex_alucon = 4'b0010;
        bus.ex_a = 32'd7; bus.ex_b = 32'd9;
        @(negedge clk);
        check("pass_alu_con", 64'(bus.alu_con), 64'(4'b0010));
        check("pass_alu_a", 64'(bus.alu_a), 64'd7);
        check("pass_alu_b", 64'(bus.alu_b), 64'd9);
        check("pass_stall", 64'(bus.stall), 64'd0);
        check("pass_result", 64'(bus.alu_result), 64'd16);
        step();
        bus.ex_valid = 1'b0;

        // 3 * 5
        run_mul(32'd3, 32'd5, sc, off, lo0);
        check("m35_stall_cycles", 64'(sc), 64'd33);
        check("m35_done_offset", 64'(off), 64'd33);
        @(negedge clk);
        check("m35_hi", 64'(bus.hi), 64'd0);
        check("m35_lo", 64'(bus.lo), 64'd15);
        step();

        // All-ones operands exercise the carry path
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, sc, off, lo0);
        @(negedge clk);
        check("mff_hi", 64'(bus.hi), 64'h00000000_FFFFFFFE);
        check("mff_lo", 64'(bus.lo), 64'h00000000_00000001);
        step();

        // Flush in the start cycle: no start
        bus.ex_valid = 1'b1; bus.ex_is_mul = 1'b1; bus.ex_flush = 1'b1;
        bus.ex_a = 32'd2; bus.ex_b = 32'd2;
        @(negedge clk);
        check("fstart_stall", 64'(bus.stall), 64'd0);
        step();
        bus.ex_flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_is_mul = 1'b0;
        @(negedge clk);
        check("fstart_stall_after", 64'(bus.stall), 64'd0);
        step();

        // Flush at RUN iteration 10
        n0 = done_cycles.size();
        bus.ex_valid = 1'b1; bus.ex_is_mul = 1'b1; bus.ex_a = 32'd5; bus.ex_b = 32'd6;
        repeat (11) step();
        bus.ex_flush = 1'b1;
        step();
        bus.ex_flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_is_mul = 1'b0;
        @(negedge clk);
        check("flush_stall", 64'(bus.stall), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'h00000000_FFFFFFFE);
        check("flush_lo", 64'(bus.lo), 64'd1);
        repeat (40) step();
        check("flush_no_done", 64'(done_cycles.size() - n0), 64'd0);

        // Reset at RUN iteration 20, then a clean multiply
        bus.ex_valid = 1'b1; bus.ex_is_mul = 1'b1; bus.ex_a = 32'd9; bus.ex_b = 32'd9;
        repeat (21) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.ex_valid = 1'b0; bus.ex_is_mul = 1'b0;
        @(negedge clk);
        check("mrst_hi", 64'(bus.hi), 64'd0);
        check("mrst_lo", 64'(bus.lo), 64'd0);
        check("mrst_stall", 64'(bus.stall), 64'd0);
        step();
        run_mul(32'd6, 32'd7, sc, off, lo0);
        @(negedge clk);
        check("m67_lo", 64'(bus.lo), 64'd42);
        check("m67_hi", 64'(bus.hi), 64'd0);
        step();

        // Back-to-back 2*3 then 4*4
        n0 = done_cycles.size();
        run_mul(32'd2, 32'd3, sc, off, lo0);
        run_mul(32'd4, 32'd4, sc, off, lo0);
        check("b2b_first_lo", 64'(lo0), 64'd6);
        check("b2b_second_offset", 64'(off), 64'd33);
        @(negedge clk);
        check("b2b_second_lo", 64'(bus.lo), 64'd16);
        check("b2b_pulses", 64'(done_cycles.size() - n0), 64'd2);
        if (done_cycles.size() - n0 == 2)
            check("b2b_gap", 64'(done_cycles[n0 + 1] - done_cycles[n0]), 64'd34);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
